// File: rtl/pool_relu_stream.sv
// rtl/pool_relu_stream.sv - streaming POOLxPOOL max-pool with optional ReLU
//
// Purpose: consumes a row-major pixel stream (all CH channels per beat) and
// emits one pooled beat per POOLxPOOL window. Only one row of per-channel
// partial maxima (one entry per pooled column) is kept.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle pulse, begins a frame from IDLE
//   in_valid/in_ready    input handshake, in_data = CH packed samples (ch0 LSBs)
//   out_valid/out_ready  output handshake, out_data = pooled (+ReLU) samples
//   out_last             marks the final pooled beat of the frame
//   busy                 high while a frame is running or flushing
//   done                 one-cycle pulse at frame completion
module pool_relu_stream #(
  parameter int DW        = 13,
  parameter int CH        = 10,
  parameter int IN_W      = 12,
  parameter int IN_H      = 12,
  parameter int POOL      = 2,
  parameter int RELU_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DW-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int OUT_W = IN_W / POOL;
  localparam int OUT_H = IN_H / POOL;
  localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int PH_W  = $clog2(POOL);
  // Pooled indices run one past the last full window for the leftover
  // columns/rows that get discarded, so size them to hold OUT_W / OUT_H.
  localparam int PC_W  = $clog2(OUT_W + 1);
  localparam int PR_W  = $clog2(OUT_H + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(POOL - 1);
  localparam logic [PC_W-1:0]  PC_LIM   = PC_W'(OUT_W);
  localparam logic [PC_W-1:0]  PC_END   = PC_W'(OUT_W - 1);
  localparam logic [PR_W-1:0]  PR_LIM   = PR_W'(OUT_H);
  localparam logic [PR_W-1:0]  PR_END   = PR_W'(OUT_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PH_W-1:0]  cph;   // col % POOL
  logic [PH_W-1:0]  rph;   // row % POOL
  logic [PC_W-1:0]  pc;    // col / POOL
  logic [PR_W-1:0]  pr;    // row / POOL

  // Partial maxima, one entry per pooled column. Never reset: the first
  // pixel of every window overwrites its entry.
  logic [CH*DW-1:0] acc_mem [0:(1<<PC_W)-1];

  logic             accept;
  logic             in_win;
  logic             win_first;
  logic             win_last;
  logic [CH*DW-1:0] acc_rd;
  logic [CH*DW-1:0] max_w;
  logic [CH*DW-1:0] res_w;

  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign busy      = (state == S_RUN) || (state == S_FLUSH);
  assign done      = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign in_win    = (pc < PC_LIM) && (pr < PR_LIM);
  assign win_first = (cph == '0) && (rph == '0);
  assign win_last  = (cph == PH_LAST) && (rph == PH_LAST);
  assign acc_rd    = acc_mem[pc];

  always_comb begin
    max_w = in_data;
    res_w = '0;
    for (int c = 0; c < CH; c++) begin
      if (!win_first && ($signed(acc_rd[c*DW +: DW]) > $signed(in_data[c*DW +: DW])))
        max_w[c*DW +: DW] = acc_rd[c*DW +: DW];
      if ((RELU_MODE != 0) && max_w[c*DW + DW - 1])
        res_w[c*DW +: DW] = '0;
      else
        res_w[c*DW +: DW] = max_w[c*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_win)
      acc_mem[pc] <= max_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      cph       <= '0;
      rph       <= '0;
      pc        <= '0;
      pr        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
            cph   <= '0;
            rph   <= '0;
            pc    <= '0;
            pr    <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              cph <= '0;
              pc  <= '0;
              row <= row + 1'b1;
              if (rph == PH_LAST) begin
                rph <= '0;
                pr  <= pr + 1'b1;
              end else begin
                rph <= rph + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
              if (cph == PH_LAST) begin
                cph <= '0;
                pc  <= pc + 1'b1;
              end else begin
                cph <= cph + 1'b1;
              end
            end
            if ((row == ROW_LAST) && (col == COL_LAST))
              state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!out_valid)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // A beat is only accepted when the output register is free or being
      // drained this cycle, so a new result never overwrites a held one.
      if (accept && in_win && win_last) begin
        out_valid <= 1'b1;
        out_data  <= res_w;
        out_last  <= (pc == PC_END) && (pr == PR_END);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
